// File: rtl/stream_in_fifo.sv
// Per-input FWFT beat FIFO in front of a crossbar slave port, tracking whole stored packets.
// Define STREAM_IN_FIFO_SAF_EN to hold output until a packet is complete (store-and-forward).
module stream_in_fifo #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_DEST_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int MAX_PACKETS  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [T_DATA_WIDTH-1:0]          s_data_i,
  input  logic [T_DEST_WIDTH-1:0]          s_dest_i,
  input  logic                             s_last_i,
  input  logic                             s_valid_i,
  output logic                             s_ready_o,
  output logic [T_DATA_WIDTH-1:0]          m_data_o,
  output logic [T_DEST_WIDTH-1:0]          m_dest_o,
  output logic                             m_last_o,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  output logic [$clog2(DEPTH):0]           fill_o,
  output logic [$clog2(MAX_PACKETS):0]     pkt_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int PW = $clog2(MAX_PACKETS) + 1;
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [PW-1:0] PKT_FULL  = PW'(MAX_PACKETS);

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic [T_DEST_WIDTH-1:0] dest;
    logic                    last;
  } beat_t;

  beat_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [FW-1:0]  r_fill;
  logic [PW-1:0]  r_pkt_cnt;
  logic           r_out_en;

  beat_t          w_head;
  logic           w_wr;
  logic           w_rd;
  logic           w_m_valid;
  logic           w_pkt_in;
  logic           w_pkt_out;

  // r_out_en keeps s_ready_o low through reset and releases it one edge later.
  assign s_ready_o = r_out_en && (r_fill != FILL_FULL) && (r_pkt_cnt != PKT_FULL);
  assign w_wr      = s_valid_i && s_ready_o;
  assign w_rd      = w_m_valid && m_ready_i;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_pkt_in  = w_wr && s_last_i;
  assign w_pkt_out = w_rd && w_head.last;

  assign m_data_o  = w_head.data;
  assign m_dest_o  = w_head.dest;
  assign m_last_o  = w_head.last;
  assign m_valid_o = w_m_valid;
  assign fill_o    = r_fill;
  assign pkt_cnt_o = r_pkt_cnt;

`ifdef STREAM_IN_FIFO_SAF_EN
  logic r_saf_release;

  // A packet longer than the FIFO can never complete; release it rather than deadlock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_saf_release <= 1'b0;
    end else if (w_pkt_out) begin
      r_saf_release <= 1'b0;
    end else if ((r_fill == FILL_FULL) && (r_pkt_cnt == '0)) begin
      r_saf_release <= 1'b1;
    end
  end

  assign w_m_valid = (r_fill != '0) && ((r_pkt_cnt != '0) || r_saf_release);
`else
  assign w_m_valid = (r_fill != '0);
`endif

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= '{data: s_data_i, dest: s_dest_i, last: s_last_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_fill    <= '0;
      r_pkt_cnt <= '0;
      r_out_en  <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd)      r_fill <= r_fill + FW'(1);
      else if (!w_wr && w_rd) r_fill <= r_fill - FW'(1);
      if (w_pkt_in && !w_pkt_out)      r_pkt_cnt <= r_pkt_cnt + PW'(1);
      else if (!w_pkt_in && w_pkt_out) r_pkt_cnt <= r_pkt_cnt - PW'(1);
    end
  end

endmodule
